fu_cdb_arbiter: RTL and testbench

Writeback-stage arbiter directly downstream of the functional units (ALU, jump, memory, multiplier, divider). Each FU delivers its finished result with destination register tag into a private one-entry holding slot. The block grants one slot per cycle, round-robin, onto a single registered result bus (CDB) that feeds the register file and scoreboard. Slots decouple fixed-latency FUs from bus contention; FUs stall only when their own slot is occupied and not being drained.

---
 rtl/fu_cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_fu_cdb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_cdb_arbiter.sv
// Purpose: writeback arbiter; one holding slot per FU, round-robin grant onto a registered CDB.
// Latency: result accepted at edge t is broadcast on the CDB in cycle t+2, for one cycle.
// Backpressure: fu_ready_o[i] drops only while slot i is full and not being drained, or during flush.
module fu_cdb_arbiter #(
  parameter int N_FU   = 5,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  localparam int FU_W  = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [N_FU-1:0]          fu_done_i,
  input  logic [N_FU*DATA_W-1:0]   fu_res_i,
  input  logic [N_FU*TAG_W-1:0]    fu_rd_i,
  output logic [N_FU-1:0]          fu_ready_o,
  output logic                     cdb_valid_o,
  output logic [DATA_W-1:0]        cdb_data_o,
  output logic [TAG_W-1:0]         cdb_rd_o,
  output logic [FU_W-1:0]          cdb_fu_o
);

  // Holding slots, one per functional unit.
  logic [N_FU-1:0]   full_q;
  logic [N_FU-1:0]   full_d;
  logic [DATA_W-1:0] data_q [N_FU];
  logic [TAG_W-1:0]  rd_q   [N_FU];

  // Round-robin pointer: index of the most recently granted slot.
  logic [FU_W-1:0]   ptr_q;

  // Arbitration results.
  logic [N_FU-1:0]   grant;
  logic [FU_W-1:0]   win_idx;
  logic              win_vld;
  logic              drain;
  logic [N_FU-1:0]   capture;

  // Registered result bus.
  logic              cdb_valid_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [TAG_W-1:0]  cdb_rd_q;
  logic [FU_W-1:0]   cdb_fu_q;

  // Find the first full slot scanning upward from ptr+1, wrapping at N_FU.
  always_comb begin
    logic [FU_W:0] cand;
    grant   = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_FU; k++) begin
      cand = {1'b0, ptr_q} + (FU_W+1)'(k);
      if (cand >= (FU_W+1)'(N_FU)) begin
        cand = cand - (FU_W+1)'(N_FU);
      end
      if (!win_vld && full_q[cand[FU_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[FU_W-1:0];
      end
    end
    if (win_vld) begin
      grant[win_idx] = 1'b1;
    end
  end

  // A flush suppresses the grant so nothing pending reaches the bus.
  assign drain = win_vld && !flush_i;

  // A slot being drained this cycle can take a new result on the same edge.
  assign fu_ready_o = flush_i ? '0 : (~full_q | grant);
  assign capture    = fu_done_i & fu_ready_o;

  // Next occupancy: refill beats drain, flush clears everything.
  always_comb begin
    full_d = full_q;
    if (flush_i) begin
      full_d = '0;
    end else begin
      full_d = (full_q & ~grant) | capture;
    end
  end

  // Slot occupancy and payload storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= '0;
      for (int i = 0; i < N_FU; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int i = 0; i < N_FU; i++) begin
        if (capture[i]) begin
          data_q[i] <= fu_res_i[i*DATA_W +: DATA_W];
          rd_q[i]   <= fu_rd_i[i*TAG_W +: TAG_W];
        end
      end
    end
  end

  // Pointer follows the winner; starts at N_FU-1 so FU0 has first priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= FU_W'(N_FU - 1);
    end else if (drain) begin
      ptr_q <= win_idx;
    end
  end

  // CDB register: valid for one cycle per grant, payload holds when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_rd_q    <= '0;
      cdb_fu_q    <= '0;
    end else if (flush_i) begin
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_valid_q <= win_vld;
      if (win_vld) begin
        cdb_data_q <= data_q[win_idx];
        cdb_rd_q   <= rd_q[win_idx];
        cdb_fu_q   <= win_idx;
      end
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_rd_o    = cdb_rd_q;
  assign cdb_fu_o    = cdb_fu_q;

  // At most one slot may be granted per cycle.
  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant));

  // Nothing is captured while a flush is in progress.
  a_no_capture_in_flush: assert property (@(posedge clk_i) disable iff (!rst_ni) !(flush_i && |capture));

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Purpose: directed scoreboard bench for fu_cdb_arbiter.
// Latency: expected broadcasts carry the exact cycle they must appear in.
// Backpressure: fu_ready is checked directly at stall and flush points.
module tb_fu_cdb_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int TW = 5;
  localparam int FW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_ni;
  logic            flush_i;
  logic [N-1:0]    fu_done;
  logic [N*DW-1:0] fu_res;
  logic [N*TW-1:0] fu_rd;
  logic [N-1:0]    fu_ready;
  logic            cdb_valid;
  logic [DW-1:0]   cdb_data;
  logic [TW-1:0]   cdb_rd;
  logic [FW-1:0]   cdb_fu;

  fu_cdb_arbiter #(.N_FU(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .fu_done_i   (fu_done),
    .fu_res_i    (fu_res),
    .fu_rd_i     (fu_rd),
    .fu_ready_o  (fu_ready),
    .cdb_valid_o (cdb_valid),
    .cdb_data_o  (cdb_data),
    .cdb_rd_o    (cdb_rd),
    .cdb_fu_o    (cdb_fu)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] rd;
    logic [FW-1:0] fu;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   p;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [DW-1:0] d, input logic [TW-1:0] r);
    fu_done[i]           = 1'b1;
    fu_res[i*DW +: DW]   = d;
    fu_rd[i*TW +: TW]    = r;
  endtask

  task automatic expect_at(input logic [DW-1:0] d, input logic [TW-1:0] r,
                           input logic [FW-1:0] f, input int c);
    exp_t e;
    e.data = d;
    e.rd   = r;
    e.fu   = f;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every broadcast must match the oldest expected entry, including its cycle.
  always @(negedge clk) begin
    if (cdb_valid === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_bcast: got data %0h rd %0d fu %0d at cycle %0d, expected none",
                 cdb_data, cdb_rd, cdb_fu, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cdb_data !== mon_e.data || cdb_rd !== mon_e.rd || cdb_fu !== mon_e.fu || cyc != mon_e.cyc) begin
          miscompares++;
          $display("FAIL bcast: got data %0h rd %0d fu %0d cycle %0d, expected data %0h rd %0d fu %0d cycle %0d",
                   cdb_data, cdb_rd, cdb_fu, cyc, mon_e.data, mon_e.rd, mon_e.fu, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    fu_done = '0;
    fu_res  = '0;
    fu_rd   = '0;

    // Reset values.
    #3;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_data",  64'(cdb_data),  64'd0);
    chk("rst_rd",    64'(cdb_rd),    64'd0);
    chk("rst_fu",    64'(cdb_fu),    64'd0);
    chk("rst_ready", 64'(fu_ready),  64'h1f);
    #19 rst_ni = 1'b1;
    step();

    // Warm-up transaction so the bus holds non-zero values.
    p = cyc;
    drive(2, 32'h55, 5'd6);
    expect_at(32'h55, 5'd6, 3'd2, p + 2);
    step(); fu_done = '0; step(3);

    // Fill all slots, reset while the first of them is on the bus.
    p = cyc;
    for (int i = 0; i < N; i++) drive(i, 32'(32'hA0 + i), 5'(i));
    expect_at(32'hA3, 5'd3, 3'd3, p + 2);
    step(); fu_done = '0; step();
    @(negedge clk); #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 64'(cdb_valid), 64'd0);
    chk("midrst_data",  64'(cdb_data),  64'd0);
    chk("midrst_rd",    64'(cdb_rd),    64'd0);
    chk("midrst_fu",    64'(cdb_fu),    64'd0);
    chk("midrst_ready", 64'(fu_ready),  64'h1f);
    step();
    @(negedge clk); #2;
    rst_ni = 1'b1;
    step(3);

    // First result after reset.
    p = cyc;
    drive(0, 32'h11, 5'd3);
    expect_at(32'h11, 5'd3, 3'd0, p + 2);
    step(); fu_done = '0; step(3);

    // Move the pointer to FU4, then all five contend.
    p = cyc;
    drive(4, 32'h44, 5'd7);
    expect_at(32'h44, 5'd7, 3'd4, p + 2);
    step(); fu_done = '0; step(3);
    p = cyc;
    for (int i = 0; i < N; i++) begin
      drive(i, 32'(32'h100 + i), 5'(i + 1));
      expect_at(32'(32'h100 + i), 5'(i + 1), 3'(i), p + 2 + i);
    end
    step(); fu_done = '0; step(5);
    step();
    chk("cont_tail_valid", 64'(cdb_valid), 64'd0);

    // Stall: slots 0 and 4 full, FU4 presents another result.
    p = cyc;
    drive(0, 32'h200, 5'd8);
    drive(4, 32'h204, 5'd9);
    expect_at(32'h200, 5'd8,  3'd0, p + 2);
    expect_at(32'h204, 5'd9,  3'd4, p + 3);
    expect_at(32'h2A4, 5'd10, 3'd4, p + 4);
    step();
    fu_done[0] = 1'b0;
    drive(4, 32'h2A4, 5'd10);
    #1;
    chk("stall_ready", 64'(fu_ready), 64'h0f);
    step();
    chk("stall_release_ready", 64'(fu_ready), 64'h1f);
    step();
    fu_done = '0;
    step(4);

    // Streaming from the divider, one result per cycle.
    p = cyc;
    for (int k = 1; k <= 8; k++) begin
      drive(4, 32'(k), 5'd12);
      expect_at(32'(k), 5'd12, 3'd4, p + k + 1);
      chk("stream_ready", 64'(fu_ready[4]), 64'd1);
      step();
    end
    fu_done = '0;
    step(4);

    // Round-robin wrap: pointer at 3, slots 1 and 4 full.
    p = cyc;
    drive(3, 32'h33, 5'd4);
    expect_at(32'h33, 5'd4, 3'd3, p + 2);
    step(); fu_done = '0; step(3);
    p = cyc;
    drive(1, 32'h3001, 5'd13);
    drive(4, 32'h3004, 5'd14);
    expect_at(32'h3004, 5'd14, 3'd4, p + 2);
    expect_at(32'h3001, 5'd13, 3'd1, p + 3);
    step(); fu_done = '0; step(4);

    // Flush with three slots full; only the already-granted result reaches the bus.
    p = cyc;
    drive(0, 32'h400, 5'd15);
    drive(2, 32'h402, 5'd16);
    drive(3, 32'h403, 5'd17);
    expect_at(32'h402, 5'd16, 3'd2, p + 2);
    step(); fu_done = '0; step();
    flush_i = 1'b1;
    drive(1, 32'hBAD, 5'd31);
    #1;
    chk("flush_ready", 64'(fu_ready), 64'd0);
    step();
    flush_i = 1'b0;
    fu_done = '0;
    #1;
    chk("flush_valid",     64'(cdb_valid), 64'd0);
    chk("flush_ready_after", 64'(fu_ready), 64'h1f);
    chk("flush_hold_data", 64'(cdb_data),  64'h402);
    step(4);

    // Pointer untouched by flush: search resumes after FU2.
    p = cyc;
    drive(0, 32'h500, 5'd18);
    drive(3, 32'h503, 5'd19);
    expect_at(32'h503, 5'd19, 3'd3, p + 2);
    expect_at(32'h500, 5'd18, 3'd0, p + 3);
    step(); fu_done = '0; step(5);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
